// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter: FSM encoding, default
// sizing and the OWNER index width.
package pci_arb_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GNT_WAIT = 2'b01,
    ST_BUSY     = 2'b10,
    ST_SWITCH   = 2'b11
  } arb_state_t;

  function automatic int owner_width(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first active-low request at ptr, ptr+1, ...
// modulo NREQ. Unknown request bits never win.
module pci_rr_picker
  import pci_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int OW   = owner_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [OW-1:0]   winner,
  output logic            valid
);

  int          sum;
  logic [OW-1:0] idx;

  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = OW'(sum);
      // An X/Z bit compares unknown, so the branch is not taken: it reads as idle.
      if (!valid && req[idx] == 1'b0) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with registered active-low grants.
// Optional grant timeout in GNT_WAIT is enabled by defining PCI_ARB_TIMEOUT_EN.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter  int NREQ    = DEF_NREQ,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int OW      = owner_width(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic            FRAME,
  input  logic            IRDY,
  output logic [NREQ-1:0] GNT,
  output logic [OW-1:0]   OWNER,
  output logic            OWNER_VALID,
  output logic            TIMEOUT_ERR
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
    $error("pci_arbiter: NREQ or TIMEOUT out of range");
  end

  arb_state_t      state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [OW-1:0]   owner_n, ptr, ptr_n, ptr_inc, pick_winner;
  logic            pick_valid, bus_idle;

  pci_rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (REQ),
    .ptr    (ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign bus_idle    = (FRAME == 1'b1) && (IRDY == 1'b1);
  assign ptr_inc     = (OWNER == OW'(NREQ - 1)) ? '0 : OWNER + 1'b1;
  assign OWNER_VALID = ~&GNT;

`ifdef PCI_ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;
  logic       tmo_n;
`endif

  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first, so no path can hold a value and infer a latch.
  always_comb begin
    state_n = state;
    gnt_n   = GNT;
    owner_n = OWNER;
    ptr_n   = ptr;
`ifdef PCI_ARB_TIMEOUT_EN
    cnt_n   = '0;
    tmo_n   = 1'b0;
`endif
    case (state)
      ST_GNT_WAIT: begin
        if (FRAME == 1'b0) begin
          state_n = ST_BUSY;
          ptr_n   = ptr_inc;
        end
`ifdef PCI_ARB_TIMEOUT_EN
        else if (bus_idle && (cnt + 8'd1 == 8'(TIMEOUT))) begin
          state_n = ST_SWITCH;
          gnt_n   = '1;
          ptr_n   = ptr_inc;
          tmo_n   = 1'b1;
        end
`endif
        else if (REQ[OWNER] == 1'b0) begin
`ifdef PCI_ARB_TIMEOUT_EN
          cnt_n = bus_idle ? cnt + 8'd1 : 8'd0;
`endif
        end else begin
          state_n = ST_SWITCH;
          gnt_n   = '1;
        end
      end
      ST_BUSY: begin
        if (bus_idle) begin
          state_n = ST_SWITCH;
          gnt_n   = '1;
        end
      end
      default: begin
        // IDLE and the single all-ones SWITCH cycle both arbitrate for the next
        // edge, so back-to-back grants are separated by exactly one idle cycle.
        state_n = ST_IDLE;
        gnt_n   = '1;
        if (pick_valid) begin
          gnt_n[pick_winner] = 1'b0;
          owner_n            = pick_winner;
          state_n            = ST_GNT_WAIT;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<='; reset is sampled on the
  // clock edge, so it is a plain branch inside the clocked block.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
      GNT   <= '1;
      OWNER <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      GNT   <= gnt_n;
      OWNER <= owner_n;
      ptr   <= ptr_n;
    end
  end

`ifdef PCI_ARB_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt         <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      TIMEOUT_ERR <= tmo_n;
    end
  end
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule
